// File: rtl/instrn_fetch_ctrl.sv
// instrn_fetch_ctrl
//   Sequences instruction fetch for the program-counter subsystem: issues a
//   req/ack handshake to instruction memory at the current PC and holds the
//   returned word until the control FSM takes it. A PC change while a fetch
//   is in flight marks that fetch stale: the handshake still completes, its
//   data is dropped and the request is reissued at the new PC. A request
//   left unacknowledged for TIMEOUT cycles raises a sticky error.
//
// Ports
//   Clk, Reset          clock (rising edge), asynchronous active-low reset
//   Fetch_En            fetch permitted
//   PC                  current program counter
//   Pc_Changed          branch/return load; in-flight or held instruction stale
//   Instrn_Taken        consumer accepts Crnt_Instrn
//   Err_Clr             clears sticky Fetch_Err
//   Imem_Req/Imem_Addr  memory request and address (address stable during Req)
//   Imem_Ack/Imem_Data  memory accept and same-cycle data
//   Crnt_Instrn         held instruction
//   Instrn_Vld          Crnt_Instrn valid and not yet taken
//   Busy                request outstanding
//   Fetch_Err           sticky ack-timeout error
module instrn_fetch_ctrl #(
  parameter int unsigned        ADDR_W     = 8,
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        TIMEOUT    = 15,
  parameter logic [DATA_W-1:0]  NOP_INSTRN = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Fetch_En,
  input  logic [ADDR_W-1:0] PC,
  input  logic              Pc_Changed,
  input  logic              Instrn_Taken,
  input  logic              Err_Clr,
  output logic              Imem_Req,
  output logic [ADDR_W-1:0] Imem_Addr,
  input  logic              Imem_Ack,
  input  logic [DATA_W-1:0] Imem_Data,
  output logic [DATA_W-1:0] Crnt_Instrn,
  output logic              Instrn_Vld,
  output logic              Busy,
  output logic              Fetch_Err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Last REQ cycle count value before timing out (count starts at 0).
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t              r_state;
  logic                r_req;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_instrn;
  logic                r_vld;
  logic                r_busy;
  logic                r_err;
  logic [7:0]          r_cnt;
  logic                r_discard;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_instrn  <= NOP_INSTRN;
      r_vld     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_discard <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Fetch_En) begin
            r_addr    <= PC;
            r_req     <= 1'b1;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_discard <= 1'b0;
            r_state   <= REQ;
          end
        end
        REQ: begin
          if (Imem_Ack) begin
            // A PC change coinciding with the ack is handled like a stale
            // fetch: drop the data and restart the handshake at the new PC.
            if (r_discard || Pc_Changed) begin
              r_discard <= 1'b0;
              r_addr    <= PC;
              r_cnt     <= '0;
            end else begin
              r_instrn <= Imem_Data;
              r_vld    <= 1'b1;
              r_req    <= 1'b0;
              r_busy   <= 1'b0;
              r_state  <= HOLD;
            end
          end else if (r_cnt == TMO_LAST) begin
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b1;
            r_discard <= 1'b0;
            r_state   <= ERR;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (Pc_Changed) begin
              r_discard <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (Pc_Changed || Instrn_Taken) begin
            r_vld <= 1'b0;
            if (Fetch_En) begin
              r_addr    <= PC;
              r_req     <= 1'b1;
              r_busy    <= 1'b1;
              r_cnt     <= '0;
              r_discard <= 1'b0;
              r_state   <= REQ;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        ERR: begin
          if (Err_Clr) begin
            r_err   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Imem_Req    = r_req;
  assign Imem_Addr   = r_addr;
  assign Crnt_Instrn = r_instrn;
  assign Instrn_Vld  = r_vld;
  assign Busy        = r_busy;
  assign Fetch_Err   = r_err;

endmodule

// File: tb/tb_instrn_fetch_ctrl.sv
module tb_instrn_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Fetch_En = 1'b0;
  logic [7:0]  PC = '0;
  logic        Pc_Changed = 1'b0;
  logic        Instrn_Taken = 1'b0;
  logic        Err_Clr = 1'b0;
  logic        Imem_Req;
  logic [7:0]  Imem_Addr;
  logic        Imem_Ack = 1'b0;
  logic [31:0] Imem_Data = '0;
  logic [31:0] Crnt_Instrn;
  logic        Instrn_Vld;
  logic        Busy;
  logic        Fetch_Err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_d;

  instrn_fetch_ctrl #(
    .ADDR_W(8), .DATA_W(32), .TIMEOUT(15), .NOP_INSTRN(32'h0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Fetch_En(Fetch_En), .PC(PC),
    .Pc_Changed(Pc_Changed), .Instrn_Taken(Instrn_Taken), .Err_Clr(Err_Clr),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Ack(Imem_Ack),
    .Imem_Data(Imem_Data), .Crnt_Instrn(Crnt_Instrn), .Instrn_Vld(Instrn_Vld),
    .Busy(Busy), .Fetch_Err(Fetch_Err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge; outputs are sampled and inputs driven 1 ns later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (Imem_Req !== 1'b0)   begin n_err++; $display("FAIL rst_req got %b want 0", Imem_Req); end
    n_vec++; if (Imem_Addr !== 8'h00) begin n_err++; $display("FAIL rst_addr got %h want 00", Imem_Addr); end
    n_vec++; if (Crnt_Instrn !== NOP) begin n_err++; $display("FAIL rst_instrn got %h want %h", Crnt_Instrn, NOP); end
    n_vec++; if ({Instrn_Vld, Busy, Fetch_Err} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b want 000", {Instrn_Vld, Busy, Fetch_Err}); end
    tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_fetch();
    Fetch_En = 1'b1; PC = 8'h10;
    tick();
    n_vec++; if ({Imem_Req, Busy} !== 2'b11) begin n_err++; $display("FAIL f1_req got %b want 11", {Imem_Req, Busy}); end
    n_vec++; if (Imem_Addr !== 8'h10) begin n_err++; $display("FAIL f1_addr got %h want 10", Imem_Addr); end
    PC = 8'h55;
    tick();
    n_vec++; if (Imem_Addr !== 8'h10 || Imem_Req !== 1'b1) begin n_err++; $display("FAIL f1_frozen got %b/%h want 1/10", Imem_Req, Imem_Addr); end
    Imem_Ack = 1'b1; Imem_Data = 32'hA5A5_0001; sb.push_back(32'hA5A5_0001);
    tick();
    Imem_Ack = 1'b0;
    n_vec++; if ({Instrn_Vld, Imem_Req, Busy} !== 3'b100) begin n_err++; $display("FAIL f1_hold got %b want 100", {Instrn_Vld, Imem_Req, Busy}); end
    exp_d = sb.pop_front();
    n_vec++; if (Crnt_Instrn !== exp_d) begin n_err++; $display("FAIL f1_data got %h want %h", Crnt_Instrn, exp_d); end
    tick();
    n_vec++; if (Instrn_Vld !== 1'b1 || Crnt_Instrn !== exp_d) begin n_err++; $display("FAIL f1_stay got %b/%h want 1/%h", Instrn_Vld, Crnt_Instrn, exp_d); end
  endtask

  task automatic test_back_to_back();
    Instrn_Taken = 1'b1; Fetch_En = 1'b1; PC = 8'h11;
    tick();
    Instrn_Taken = 1'b0;
    n_vec++; if ({Instrn_Vld, Imem_Req} !== 2'b01) begin n_err++; $display("FAIL b2b_req got %b want 01", {Instrn_Vld, Imem_Req}); end
    n_vec++; if (Imem_Addr !== 8'h11) begin n_err++; $display("FAIL b2b_addr got %h want 11", Imem_Addr); end
    Imem_Ack = 1'b1; Imem_Data = 32'h1111_0002; sb.push_back(32'h1111_0002);
    tick();
    Imem_Ack = 1'b0;
    exp_d = sb.pop_front();
    n_vec++; if (Instrn_Vld !== 1'b1 || Crnt_Instrn !== exp_d) begin n_err++; $display("FAIL b2b_data got %b/%h want 1/%h", Instrn_Vld, Crnt_Instrn, exp_d); end
  endtask

  task automatic test_flush_in_req();
    Instrn_Taken = 1'b1; Fetch_En = 1'b1; PC = 8'h20;
    tick();
    Instrn_Taken = 1'b0;
    n_vec++; if (Imem_Addr !== 8'h20 || Imem_Req !== 1'b1) begin n_err++; $display("FAIL fl_start got %b/%h want 1/20", Imem_Req, Imem_Addr); end
    Pc_Changed = 1'b1; PC = 8'h40;
    tick();
    Pc_Changed = 1'b0;
    n_vec++; if (Imem_Addr !== 8'h20 || Imem_Req !== 1'b1) begin n_err++; $display("FAIL fl_nochg got %b/%h want 1/20", Imem_Req, Imem_Addr); end
    Imem_Ack = 1'b1; Imem_Data = 32'h0000_DEAD;
    tick();
    n_vec++; if ({Imem_Req, Busy, Instrn_Vld} !== 3'b110) begin n_err++; $display("FAIL fl_drop got %b want 110", {Imem_Req, Busy, Instrn_Vld}); end
    n_vec++; if (Imem_Addr !== 8'h40) begin n_err++; $display("FAIL fl_reissue got %h want 40", Imem_Addr); end
    Imem_Data = 32'h1234_5678; sb.push_back(32'h1234_5678);
    tick();
    Imem_Ack = 1'b0;
    exp_d = sb.pop_front();
    n_vec++; if (Instrn_Vld !== 1'b1 || Crnt_Instrn !== exp_d) begin n_err++; $display("FAIL fl_data got %b/%h want 1/%h", Instrn_Vld, Crnt_Instrn, exp_d); end
  endtask

  task automatic test_timeout();
    int unsigned req_cycles = 0;
    Instrn_Taken = 1'b1; Fetch_En = 1'b1; PC = 8'h30;
    tick();
    Instrn_Taken = 1'b0; Fetch_En = 1'b0;
    for (int i = 0; i < 40 && Imem_Req === 1'b1; i++) begin
      req_cycles++;
      tick();
    end
    n_vec++; if (req_cycles != 15) begin n_err++; $display("FAIL to_len got %0d want 15", req_cycles); end
    n_vec++; if ({Imem_Req, Busy, Instrn_Vld, Fetch_Err} !== 4'b0001) begin n_err++; $display("FAIL to_err got %b want 0001", {Imem_Req, Busy, Instrn_Vld, Fetch_Err}); end
    Pc_Changed = 1'b1; Fetch_En = 1'b1;
    tick();
    Pc_Changed = 1'b0;
    n_vec++; if ({Imem_Req, Fetch_Err} !== 2'b01) begin n_err++; $display("FAIL to_sticky got %b want 01", {Imem_Req, Fetch_Err}); end
    Fetch_En = 1'b0; Err_Clr = 1'b1;
    tick();
    Err_Clr = 1'b0;
    n_vec++; if ({Imem_Req, Fetch_Err} !== 2'b00) begin n_err++; $display("FAIL to_clr got %b want 00", {Imem_Req, Fetch_Err}); end
    Fetch_En = 1'b1; PC = 8'h31;
    tick();
    n_vec++; if (Imem_Req !== 1'b1 || Imem_Addr !== 8'h31) begin n_err++; $display("FAIL to_refetch got %b/%h want 1/31", Imem_Req, Imem_Addr); end
    Imem_Ack = 1'b1; Imem_Data = 32'h3131_0004; sb.push_back(32'h3131_0004);
    tick();
    Imem_Ack = 1'b0;
    exp_d = sb.pop_front();
    n_vec++; if (Instrn_Vld !== 1'b1 || Crnt_Instrn !== exp_d) begin n_err++; $display("FAIL to_data got %b/%h want 1/%h", Instrn_Vld, Crnt_Instrn, exp_d); end
  endtask

  task automatic test_async_reset();
    Instrn_Taken = 1'b1; Fetch_En = 1'b1; PC = 8'h50;
    tick();
    Instrn_Taken = 1'b0;
    n_vec++; if (Imem_Req !== 1'b1) begin n_err++; $display("FAIL ar_pre got %b want 1", Imem_Req); end
    #2 Reset = 1'b0;
    #1;
    n_vec++; if ({Imem_Req, Busy, Instrn_Vld, Fetch_Err} !== 4'b0000) begin n_err++; $display("FAIL ar_flags got %b want 0000", {Imem_Req, Busy, Instrn_Vld, Fetch_Err}); end
    n_vec++; if (Imem_Addr !== 8'h00 || Crnt_Instrn !== NOP) begin n_err++; $display("FAIL ar_vals got %h/%h want 00/%h", Imem_Addr, Crnt_Instrn, NOP); end
    Fetch_En = 1'b0;
    #2 Reset = 1'b1;
    Imem_Ack = 1'b1; Imem_Data = 32'hBAD0_0005;
    tick();
    Imem_Ack = 1'b0;
    n_vec++; if ({Instrn_Vld, Imem_Req} !== 2'b00 || Crnt_Instrn !== NOP) begin n_err++; $display("FAIL ar_late got %b/%h want 00/%h", {Instrn_Vld, Imem_Req}, Crnt_Instrn, NOP); end
  endtask

  task automatic test_flush_in_hold();
    Fetch_En = 1'b1; PC = 8'h60;
    tick();
    Imem_Ack = 1'b1; Imem_Data = 32'hC0DE_0006; sb.push_back(32'hC0DE_0006);
    tick();
    Imem_Ack = 1'b0;
    exp_d = sb.pop_front();
    n_vec++; if (Instrn_Vld !== 1'b1 || Crnt_Instrn !== exp_d) begin n_err++; $display("FAIL fh_data got %b/%h want 1/%h", Instrn_Vld, Crnt_Instrn, exp_d); end
    Pc_Changed = 1'b1; Instrn_Taken = 1'b1; PC = 8'h80;
    tick();
    Pc_Changed = 1'b0; Instrn_Taken = 1'b0;
    n_vec++; if ({Instrn_Vld, Imem_Req} !== 2'b01 || Imem_Addr !== 8'h80) begin n_err++; $display("FAIL fh_reissue got %b/%h want 01/80", {Instrn_Vld, Imem_Req}, Imem_Addr); end
    n_vec++; if (Crnt_Instrn !== exp_d) begin n_err++; $display("FAIL fh_keep got %h want %h", Crnt_Instrn, exp_d); end
    // PC change in the same cycle as the ack drops the data and reissues.
    Imem_Ack = 1'b1; Pc_Changed = 1'b1; PC = 8'h90; Imem_Data = 32'hBAD0_0007;
    tick();
    Pc_Changed = 1'b0;
    n_vec++; if ({Instrn_Vld, Imem_Req} !== 2'b01 || Imem_Addr !== 8'h90) begin n_err++; $display("FAIL fh_ackchg got %b/%h want 01/90", {Instrn_Vld, Imem_Req}, Imem_Addr); end
    Imem_Data = 32'h9090_0008; sb.push_back(32'h9090_0008);
    tick();
    Imem_Ack = 1'b0;
    exp_d = sb.pop_front();
    n_vec++; if (Instrn_Vld !== 1'b1 || Crnt_Instrn !== exp_d) begin n_err++; $display("FAIL fh_data2 got %b/%h want 1/%h", Instrn_Vld, Crnt_Instrn, exp_d); end
    Instrn_Taken = 1'b1; Fetch_En = 1'b0;
    tick();
    Instrn_Taken = 1'b0;
    n_vec++; if ({Instrn_Vld, Imem_Req, Busy} !== 3'b000 || Crnt_Instrn !== exp_d) begin n_err++; $display("FAIL fh_idle got %b/%h want 000/%h", {Instrn_Vld, Imem_Req, Busy}, Crnt_Instrn, exp_d); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_flush_in_req();
    test_timeout();
    test_async_reset();
    test_flush_in_hold();
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_empty got %0d want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
